// File: rtl/cplx_acc_pkg.sv
// ----------------------------------------------------------------------------
// cplx_acc_pkg
// Shared definitions for the complex block accumulator:
//   - default sample / accumulator widths
//   - FSM state encoding (IDLE / ACC / HOLD)
//   - Q7.8 saturation limits
//   - block-length decode helper (len==0 means 256 samples)
// ----------------------------------------------------------------------------
package cplx_acc_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 24;
    localparam int CNT_W  = 9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    // An 8-bit length field of zero encodes the full 256-sample block.
    function automatic logic [CNT_W-1:0] blk_len(input logic [7:0] l);
        return (l == 8'd0) ? 9'd256 : {1'b0, l};
    endfunction

endpackage

// File: rtl/sat_trunc.sv
// ----------------------------------------------------------------------------
// sat_trunc
// Narrows a signed IW-bit value to a signed OW-bit value, clamping to the
// OW-bit two's-complement range instead of wrapping.
// Ports:
//   din   in   IW  signed wide value (accumulator)
//   dout  out  OW  clamped signed result
//   sat   out  1   high when din was outside the OW-bit range
// ----------------------------------------------------------------------------
module sat_trunc
    import cplx_acc_pkg::*;
#(
    parameter int IW = AW_DEF,
    parameter int OW = DW_DEF
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 sat
);

    // OW-bit limits sign-extended to IW bits so the compare is exact.
    localparam logic signed [IW-1:0] MAX_EXT = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] MIN_EXT = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        dout = din[OW-1:0];
        sat  = 1'b0;
        if (din > MAX_EXT) begin
            dout = MAX_EXT[OW-1:0];
            sat  = 1'b1;
        end else if (din < MIN_EXT) begin
            dout = MIN_EXT[OW-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/cplx_acc.sv
// ----------------------------------------------------------------------------
// cplx_acc
// Accumulates a block of len complex samples (Q7.8, real + imaginary) from a
// complex MAC, then presents the saturated block sums until downstream takes
// them. The accumulator is wide enough for 256 full-scale samples, so
// clamping happens only once, on the way out.
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_r, in_j          sample real / imaginary part (signed Q7.8)
//   in_ovf              MAC overflow flag for this sample
//   len                 samples per block (0 = 256), sampled on the first
//                       transfer of a block
//   out_valid/out_ready output handshake
//   out_r, out_j        saturated block sums
//   out_sat             either part was clamped
//   out_ovf             any in_ovf seen during the block
//   busy                a block is in progress
// ----------------------------------------------------------------------------
module cplx_acc
    import cplx_acc_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_j,
    input  logic          in_ovf,
    input  logic [7:0]    len,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_j,
    output logic          out_sat,
    output logic          out_ovf,
    output logic          busy
);

    logic [1:0]              state;
    logic [CNT_W-1:0]        len_q;
    logic [CNT_W-1:0]        cnt;
    logic signed [AW-1:0]    acc_r;
    logic signed [AW-1:0]    acc_j;
    logic                    ovf_q;

    logic                    in_fire;
    logic signed [AW-1:0]    ext_r;
    logic signed [AW-1:0]    ext_j;
    logic signed [AW-1:0]    acc_r_nxt;
    logic signed [AW-1:0]    acc_j_nxt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [CNT_W-1:0]        len_eff;
    logic                    ovf_nxt;
    logic                    done;
    logic signed [DW-1:0]    sat_r;
    logic signed [DW-1:0]    sat_j;
    logic                    sat_r_flag;
    logic                    sat_j_flag;

    assign in_ready  = (state != ST_HOLD);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign in_fire   = in_valid && in_ready;

    assign ext_r = {{(AW-DW){in_r[DW-1]}}, in_r};
    assign ext_j = {{(AW-DW){in_j[DW-1]}}, in_j};

    // Next accumulator/count values for a transfer in this cycle. In IDLE the
    // sample starts a fresh block, so the live len input is used; afterwards
    // the latched length governs the block.
    always_comb begin
        len_eff   = len_q;
        acc_r_nxt = acc_r + ext_r;
        acc_j_nxt = acc_j + ext_j;
        cnt_nxt   = cnt + 9'd1;
        ovf_nxt   = ovf_q | in_ovf;
        if (state == ST_IDLE) begin
            len_eff   = blk_len(len);
            acc_r_nxt = ext_r;
            acc_j_nxt = ext_j;
            cnt_nxt   = 9'd1;
            ovf_nxt   = in_ovf;
        end
        done = (cnt_nxt == len_eff);
    end

    // Clamp the value the accumulator is about to take, so the result can be
    // registered on the same edge that enters HOLD.
    sat_trunc #(.IW(AW), .OW(DW)) u_sat_r (
        .din  (acc_r_nxt),
        .dout (sat_r),
        .sat  (sat_r_flag)
    );

    sat_trunc #(.IW(AW), .OW(DW)) u_sat_j (
        .din  (acc_j_nxt),
        .dout (sat_j),
        .sat  (sat_j_flag)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            cnt     <= '0;
            acc_r   <= '0;
            acc_j   <= '0;
            ovf_q   <= 1'b0;
            out_r   <= '0;
            out_j   <= '0;
            out_sat <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACC: begin
                    if (in_fire) begin
                        acc_r <= acc_r_nxt;
                        acc_j <= acc_j_nxt;
                        cnt   <= cnt_nxt;
                        ovf_q <= ovf_nxt;
                        if (state == ST_IDLE) begin
                            len_q <= len_eff;
                        end
                        if (done) begin
                            state   <= ST_HOLD;
                            out_r   <= sat_r;
                            out_j   <= sat_j;
                            out_sat <= sat_r_flag | sat_j_flag;
                            out_ovf <= ovf_nxt;
                        end else begin
                            state <= ST_ACC;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cplx_acc.sv
// ----------------------------------------------------------------------------
// tb_cplx_acc
// Directed and randomized stimulus for cplx_acc, checked against a
// block-level reference model built from integer sums and clamping.
// ----------------------------------------------------------------------------
module tb_cplx_acc;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_r;
    logic [15:0] in_j;
    logic        in_ovf;
    logic [7:0]  len;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_r;
    logic [15:0] out_j;
    logic        out_sat;
    logic        out_ovf;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_hold;
    int          m_n;
    int          m_len;
    int          m_sr;
    int          m_sj;
    bit          m_ovf;
    int          m_acc_cnt;
    logic [15:0] e_r;
    logic [15:0] e_j;
    bit          e_sat;
    bit          e_ovf;

    cplx_acc dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_j      (in_j),
        .in_ovf    (in_ovf),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_j     (out_j),
        .out_sat   (out_sat),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] clamp(input int s);
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    function automatic bit clipped(input int s);
        return (s > 32767) || (s < -32768);
    endfunction

    task automatic model_reset();
        m_hold = 0; m_n = 0; m_len = 0; m_sr = 0; m_sj = 0; m_ovf = 0;
        e_r = 16'h0; e_j = 16'h0; e_sat = 0; e_ovf = 0;
    endtask

    // One clock cycle: drive inputs at the falling edge, advance the model on
    // the rising edge, then compare the DUT against the model.
    task automatic step(input bit v, input logic [15:0] r, input logic [15:0] j,
                        input bit o, input logic [7:0] l, input bit rdy);
        int sr;
        int sj;
        @(negedge clk);
        in_valid = v; in_r = r; in_j = j; in_ovf = o; len = l; out_ready = rdy;
        #1;
        chk("in_ready", in_ready, !m_hold);
        @(posedge clk);
        if (m_hold) begin
            if (rdy) m_hold = 0;
        end else if (v) begin
            if (m_n == 0) begin
                m_len = (l == 8'd0) ? 256 : int'(l);
                m_sr = 0; m_sj = 0; m_ovf = 0;
            end
            sr = $signed(r);
            sj = $signed(j);
            m_sr += sr;
            m_sj += sj;
            m_ovf |= o;
            m_n++;
            m_acc_cnt++;
            if (m_n == m_len) begin
                m_hold = 1;
                m_n    = 0;
                e_r    = clamp(m_sr);
                e_j    = clamp(m_sj);
                e_sat  = clipped(m_sr) || clipped(m_sj);
                e_ovf  = m_ovf;
            end
        end
        #1;
        chk("out_valid", out_valid, m_hold);
        chk("busy", busy, m_hold || (m_n != 0));
        if (m_hold) begin
            chk("out_r", out_r, e_r);
            chk("out_j", out_j, e_j);
            chk("out_sat", out_sat, e_sat);
            chk("out_ovf", out_ovf, e_ovf);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_r", out_r, 16'h0);
        chk("rst_j", out_j, 16'h0);
        chk("rst_sat", out_sat, 1'b0);
        chk("rst_ovf", out_ovf, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        rstn = 1'b0; in_valid = 0; in_r = 0; in_j = 0; in_ovf = 0; len = 0; out_ready = 0;
        model_reset();
        m_acc_cnt = 0;
        #12;
        chk("por_valid", out_valid, 1'b0);
        chk("por_busy", busy, 1'b0);
        chk("por_r", out_r, 16'h0);
        chk("por_j", out_j, 16'h0);
        do_reset();

        // len=4, four (1.0, -1.0) samples; result valid right after the 4th
        for (int i = 0; i < 4; i++) step(1, 16'h0100, 16'hFF00, 0, 8'd4, 1);
        chk("b4_valid", out_valid, 1'b1);
        chk("b4_r", out_r, 16'h0400);
        chk("b4_j", out_j, 16'hFC00);
        chk("b4_sat", out_sat, 1'b0);
        chk("b4_ovf", out_ovf, 1'b0);
        step(0, 16'h0, 16'h0, 0, 8'd4, 1);
        chk("b4_valid_1cyc", out_valid, 1'b0);

        // len=1 goes straight to HOLD and reports the overflow flag
        step(1, 16'h1234, 16'h8000, 1, 8'd1, 1);
        chk("b1_r", out_r, 16'h1234);
        chk("b1_j", out_j, 16'h8000);
        chk("b1_ovf", out_ovf, 1'b1);
        chk("b1_sat", out_sat, 1'b0);
        step(0, 16'h0, 16'h0, 0, 8'd1, 1);

        // len=0 means 256 full-scale samples; both parts clamp
        m_acc_cnt = 0;
        for (int i = 0; i < 255; i++) step(1, 16'h7FFF, 16'h8000, 0, 8'd0, 1);
        chk("b256_not_yet", out_valid, 1'b0);
        step(1, 16'h7FFF, 16'h8000, 0, 8'd0, 1);
        chk("b256_count", m_acc_cnt, 256);
        chk("b256_valid", out_valid, 1'b1);
        chk("b256_r", out_r, 16'h7FFF);
        chk("b256_j", out_j, 16'h8000);
        chk("b256_sat", out_sat, 1'b1);
        step(0, 16'h0, 16'h0, 0, 8'd0, 1);

        // len=3 with backpressure: samples offered during HOLD must not be taken
        for (int i = 0; i < 3; i++) step(1, 16'h0010, 16'hFFF0, 0, 8'd3, 0);
        for (int i = 0; i < 10; i++) step(1, 16'h5555, 16'h2222, 1, 8'd3, 0);
        chk("bp_r", out_r, 16'h0030);
        chk("bp_j", out_j, 16'hFFD0);
        step(1, 16'h5555, 16'h2222, 1, 8'd2, 1);
        for (int i = 0; i < 2; i++) step(1, 16'h0001, 16'h0002, 0, 8'd2, 1);
        chk("bp_next_r", out_r, 16'h0002);
        chk("bp_next_j", out_j, 16'h0004);
        chk("bp_next_ovf", out_ovf, 1'b0);
        step(0, 16'h0, 16'h0, 0, 8'd2, 1);

        // reset in the middle of a len=8 block discards the partial sum
        for (int i = 0; i < 5; i++) step(1, 16'h0100, 16'h0100, 1, 8'd8, 1);
        do_reset();
        for (int i = 0; i < 2; i++) step(1, 16'h0080, 16'h0080, 0, 8'd2, 1);
        chk("rb_r", out_r, 16'h0100);
        chk("rb_j", out_j, 16'h0100);
        chk("rb_ovf", out_ovf, 1'b0);
        step(0, 16'h0, 16'h0, 0, 8'd2, 1);

        // len=6 with random in_valid: partial sum 3*0x7000 overflows 16 bits,
        // the full block returns to zero; len changes mid-block are ignored
        for (int i = 0; i < 200 && !m_hold; i++) begin
            if (m_n < 3) step(1'($urandom_range(0, 1)), 16'h7000, 16'h9000, 0,
                              (m_n == 0) ? 8'd6 : 8'($urandom), 1);
            else         step(1'($urandom_range(0, 1)), 16'h9000, 16'h7000, 0,
                              8'($urandom), 1);
        end
        chk("rv_valid", out_valid, 1'b1);
        chk("rv_r", out_r, 16'h0000);
        chk("rv_j", out_j, 16'h0000);
        chk("rv_sat", out_sat, 1'b0);
        step(0, 16'h0, 16'h0, 0, 8'd6, 1);

        // fully random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 15) == 0), 8'($urandom_range(1, 12)),
                 1'($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
